// File: rtl/lc3b_pkg.sv
// lc3b_pkg
// Shared definitions for the LC-3b memory controller: the access FSM state
// encoding, the DATA_SIZE / R_W encodings used by the datapath, and the
// minimum access latency. The counter width covers MEM_LATENCY up to 15.
package lc3b_pkg;

    typedef enum logic [1:0] {
        IDLE,
        STROBE,
        WAIT,
        DONE
    } mem_state_e;

    localparam logic SIZE_BYTE = 1'b0;
    localparam logic SIZE_WORD = 1'b1;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    localparam int MIN_LATENCY = 3;
    localparam int CNT_W       = 4;

endpackage

// File: rtl/lc3b_mem_lanes.sv
// lc3b_mem_lanes
// Combinational byte-lane unit. A word access enables both lanes and passes
// the write data through; a byte access enables the lane chosen by the low
// address bit and replicates the low data byte onto both lanes, so the SRAM
// sees the byte in whichever lane is enabled.
//
// Ports:
//   size   in   1   1 = word, 0 = byte
//   addr0  in   1   byte address bit 0
//   mdr    in  16   write data from the datapath
//   be     out  2   byte enables, [1] is the high byte
//   wdata  out 16   lane-aligned write data
module lc3b_mem_lanes
    import lc3b_pkg::*;
(
    input  logic        size,
    input  logic        addr0,
    input  logic [15:0] mdr,
    output logic [1:0]  be,
    output logic [15:0] wdata
);

    always_comb begin
        be    = 2'b11;
        wdata = mdr;
        unique case (size)
            SIZE_WORD: begin
                be    = 2'b11;
                wdata = mdr;
            end
            SIZE_BYTE: begin
                be    = addr0 ? 2'b10 : 2'b01;
                wdata = {mdr[7:0], mdr[7:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lc3b_mem_ctrl.sv
// lc3b_mem_ctrl
// Memory controller between the LC-3b datapath memory interface and a
// single-port synchronous SRAM. One access at a time, exactly one SRAM
// strobe per access, and a one-cycle ready pulse R exactly MEM_LATENCY
// cycles after acceptance (acceptance cycle counted as cycle 1).
//
// Optional feature macro: LC3B_UNALIGNED_CHECK_EN. When defined, a word
// access to an odd address issues no strobe and raises `unaligned` with R.
//
// Ports:
//   clk         in   1   clock, rising edge
//   rst         in   1   asynchronous active-low reset
//   MIO_EN      in   1   access request, sampled only in IDLE
//   R_W         in   1   1 = write, 0 = read
//   DATA_SIZE   in   1   1 = word, 0 = byte
//   MAR         in  16   byte address
//   MDR         in  16   write data
//   mem_rdata   out 16   registered read word
//   R           out  1   ready pulse
//   unaligned   out  1   misaligned word access flag (macro builds only)
//   sram_en     out  1   SRAM strobe
//   sram_we     out  1   SRAM write enable
//   sram_be     out  2   SRAM byte enables
//   sram_addr   out AW   SRAM word address
//   sram_wdata  out 16   SRAM write data
//   sram_rdata  in  16   SRAM read data, valid one cycle after a read strobe
module lc3b_mem_ctrl
    import lc3b_pkg::*;
#(
    parameter int MEM_LATENCY = 5,
    parameter int AW          = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          MIO_EN,
    input  logic          R_W,
    input  logic          DATA_SIZE,
    input  logic [15:0]   MAR,
    input  logic [15:0]   MDR,
    output logic [15:0]   mem_rdata,
    output logic          R,
`ifdef LC3B_UNALIGNED_CHECK_EN
    output logic          unaligned,
`endif
    output logic          sram_en,
    output logic          sram_we,
    output logic [1:0]    sram_be,
    output logic [AW-1:0] sram_addr,
    output logic [15:0]   sram_wdata,
    input  logic [15:0]   sram_rdata
);

    // Number of WAIT cycles between STROBE and DONE.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - MIN_LATENCY);

    mem_state_e       state, next_state;
    logic [CNT_W-1:0] cnt, next_cnt;
    logic             next_sram_en;
    logic             next_r;
    logic             accept;
    logic             suppress;
    logic             capture;
    logic [1:0]       lane_be;
    logic [15:0]      lane_wdata;

    assign accept = (state == IDLE) && MIO_EN;

`ifdef LC3B_UNALIGNED_CHECK_EN
    logic req_bad;
    assign suppress = (DATA_SIZE == SIZE_WORD) && MAR[0];
`else
    assign suppress = 1'b0;
`endif

    // Lane selection works on the live request; its result is latched at
    // acceptance together with the rest of the request.
    lc3b_mem_lanes u_lanes (
        .size  (DATA_SIZE),
        .addr0 (MAR[0]),
        .mdr   (MDR),
        .be    (lane_be),
        .wdata (lane_wdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    // Outputs are registered, so the strobe and ready values are decided
    // one cycle early: strobe on acceptance, ready on the transition into
    // DONE. With the minimum latency STROBE goes straight to DONE.
    always_comb begin
        next_state   = state;
        next_cnt     = cnt;
        next_sram_en = 1'b0;
        next_r       = 1'b0;
        unique case (state)
            IDLE: begin
                if (MIO_EN) begin
                    next_state   = STROBE;
                    next_cnt     = CNT_LOAD;
                    next_sram_en = !suppress;
                end
            end
            STROBE: begin
                if (cnt == '0) begin
                    next_state = DONE;
                    next_r     = 1'b1;
                end else begin
                    next_state = WAIT;
                end
            end
            WAIT: begin
                next_cnt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    next_state = DONE;
                    next_r     = 1'b1;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // The request is frozen at acceptance. Read data is captured one edge
    // after the SRAM returns it, and only if a read strobe was really issued.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sram_en    <= 1'b0;
            sram_we    <= 1'b0;
            sram_be    <= '0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            R          <= 1'b0;
            capture    <= 1'b0;
            mem_rdata  <= '0;
        end else begin
            sram_en <= next_sram_en;
            R       <= next_r;
            capture <= (state == STROBE) && sram_en && (sram_we == RW_READ);
            if (capture) begin
                mem_rdata <= sram_rdata;
            end
            if (accept) begin
                sram_we    <= (R_W == RW_WRITE);
                sram_addr  <= MAR[AW:1];
                sram_be    <= lane_be;
                sram_wdata <= lane_wdata;
            end
        end
    end

`ifdef LC3B_UNALIGNED_CHECK_EN
    // The misalignment flag rides along with the access and is reported
    // in the same cycle as R.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_bad   <= 1'b0;
            unaligned <= 1'b0;
        end else begin
            if (accept) begin
                req_bad <= suppress;
            end
            unaligned <= next_r && req_bad;
        end
    end
`endif

endmodule

// File: tb/tb_lc3b_mem_ctrl.sv
// tb_lc3b_mem_ctrl
// Self-checking bench for lc3b_mem_ctrl with a behavioural SRAM and a
// word-level reference memory. Follows LC3B_UNALIGNED_CHECK_EN if defined.
module tb_lc3b_mem_ctrl;

    localparam int L  = 5;
    localparam int AW = 15;

    logic          clk;
    logic          rst;
    logic          MIO_EN;
    logic          R_W;
    logic          DATA_SIZE;
    logic [15:0]   MAR;
    logic [15:0]   MDR;
    logic [15:0]   mem_rdata;
    logic          R;
`ifdef LC3B_UNALIGNED_CHECK_EN
    logic          unaligned;
`endif
    logic          sram_en;
    logic          sram_we;
    logic [1:0]    sram_be;
    logic [AW-1:0] sram_addr;
    logic [15:0]   sram_wdata;
    logic [15:0]   sram_rdata;

    int checks   = 0;
    int failures = 0;

    lc3b_mem_ctrl #(
        .MEM_LATENCY (L),
        .AW          (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .MIO_EN     (MIO_EN),
        .R_W        (R_W),
        .DATA_SIZE  (DATA_SIZE),
        .MAR        (MAR),
        .MDR        (MDR),
        .mem_rdata  (mem_rdata),
        .R          (R),
`ifdef LC3B_UNALIGNED_CHECK_EN
        .unaligned  (unaligned),
`endif
        .sram_en    (sram_en),
        .sram_we    (sram_we),
        .sram_be    (sram_be),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Power-on contents of every word, shared by the SRAM and the model.
    function automatic logic [15:0] dflt(input int a);
        return 16'((a * 40503) ^ 32'h5AC3);
    endfunction

    // Behavioural synchronous SRAM.
    logic [15:0] sram_mem [0:32767];
    bit          written  [0:32767];
    logic [15:0] cur;

    always @(posedge clk) begin
        if (sram_en) begin
            cur = written[sram_addr] ? sram_mem[sram_addr] : dflt(int'(sram_addr));
            if (sram_we) begin
                if (sram_be[0]) cur[7:0]  = sram_wdata[7:0];
                if (sram_be[1]) cur[15:8] = sram_wdata[15:8];
                sram_mem[sram_addr] <= cur;
                written[sram_addr]  <= 1'b1;
            end else begin
                sram_rdata <= cur;
            end
        end
    end

    // Reference model: word-addressed memory plus expected mem_rdata.
    logic [15:0] ref_mem [int];
    logic [15:0] exp_rdata;

    function automatic logic [15:0] ref_read(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete access from acceptance (cycle 1) to R (cycle L). Request
    // inputs are disturbed right after acceptance to prove they are frozen.
    task automatic applyStimulus(input logic rw, input logic sz, input logic [15:0] addr,
                                 input logic [15:0] data, input bit hold,
                                 input logic [15:0] mar_late);
        int          wa;
        logic        bad;
        logic [1:0]  ebe;
        logic [15:0] ewd;
        logic [15:0] w;
        wa  = int'(addr[15:1]);
        bad = 1'b0;
`ifdef LC3B_UNALIGNED_CHECK_EN
        bad = sz && addr[0];
`endif
        ebe = sz ? 2'b11 : (addr[0] ? 2'b10 : 2'b01);
        ewd = sz ? data : {data[7:0], data[7:0]};
        @(negedge clk);
        chk1("idle_R", R, 1'b0);
        chk1("idle_en", sram_en, 1'b0);
        MIO_EN    = 1'b1;
        R_W       = rw;
        DATA_SIZE = sz;
        MAR       = addr;
        MDR       = data;
        if (!bad) begin
            if (rw) begin
                w = ref_read(wa);
                if (sz)           w        = data;
                else if (addr[0]) w[15:8]  = data[7:0];
                else              w[7:0]   = data[7:0];
                ref_mem[wa] = w;
            end else begin
                exp_rdata = ref_read(wa);
            end
        end
        for (int k = 2; k <= L; k++) begin
            @(posedge clk);
            #1;
            if (k == 2) begin
                if (!hold) MIO_EN = 1'b0;
                MAR       = mar_late;
                MDR       = 16'($urandom);
                R_W       = ~rw;
                DATA_SIZE = ~sz;
            end
            @(negedge clk);
            chk1("strobe_en", sram_en, (k == 2) && !bad);
            if (k == 2 && !bad) begin
                chk1("strobe_we", sram_we, rw);
                chk16("strobe_addr", {1'b0, sram_addr}, 16'(wa));
                chk16("strobe_be", {14'b0, sram_be}, {14'b0, ebe});
                if (rw) chk16("strobe_wdata", sram_wdata, ewd);
            end
            chk1("ready", R, k == L);
`ifdef LC3B_UNALIGNED_CHECK_EN
            chk1("unaligned", unaligned, (k == L) && bad);
`endif
            if (k == L) chk16("rdata", mem_rdata, exp_rdata);
        end
    endtask

    // Watch a few idle cycles: nothing may be strobed and R must stay low.
    task automatic checkOutput(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk1({tag, "_en"}, sram_en, 1'b0);
            chk1({tag, "_R"}, R, 1'b0);
        end
    endtask

    initial begin
        logic       rw;
        logic       sz;
        bit         hold;
        logic [15:0] a;
        rst       = 1'b0;
        MIO_EN    = 1'b0;
        R_W       = 1'b0;
        DATA_SIZE = 1'b0;
        MAR       = '0;
        MDR       = '0;
        exp_rdata = '0;

        repeat (2) @(negedge clk);
        chk1("rst_R", R, 1'b0);
        chk1("rst_en", sram_en, 1'b0);
        chk1("rst_we", sram_we, 1'b0);
        chk16("rst_be", {14'b0, sram_be}, 16'h0000);
        chk16("rst_addr", {1'b0, sram_addr}, 16'h0000);
        chk16("rst_wdata", sram_wdata, 16'h0000);
        chk16("rst_rdata", mem_rdata, 16'h0000);
`ifdef LC3B_UNALIGNED_CHECK_EN
        chk1("rst_unaligned", unaligned, 1'b0);
`endif
        rst = 1'b1;

        $display("[TB] word write/read at 3000");
        applyStimulus(1'b1, 1'b1, 16'h3000, 16'hBEEF, 1'b0, 16'hFFFF);
        applyStimulus(1'b0, 1'b1, 16'h3000, 16'h0000, 1'b0, 16'h1234);
        chk16("beef", exp_rdata, 16'hBEEF);

        $display("[TB] byte write at 3001");
        applyStimulus(1'b1, 1'b0, 16'h3001, 16'h00A5, 1'b0, 16'h0000);
        applyStimulus(1'b0, 1'b1, 16'h3000, 16'h0000, 1'b0, 16'h0000);
        chk16("byte_merge", mem_rdata, 16'hA5EF);

        $display("[TB] back-to-back reads");
        applyStimulus(1'b0, 1'b1, 16'h0010, 16'h0000, 1'b1, 16'h0010);
        applyStimulus(1'b0, 1'b1, 16'h0020, 16'h0000, 1'b0, 16'h0020);

        $display("[TB] MAR changed after acceptance");
        applyStimulus(1'b0, 1'b1, 16'h0100, 16'h0000, 1'b0, 16'hFFFF);

        $display("[TB] reset in cycle 3 of a write");
        @(negedge clk);
        MIO_EN = 1'b1; R_W = 1'b1; DATA_SIZE = 1'b1; MAR = 16'h0200; MDR = 16'h1234;
        ref_mem[16'h0100] = 16'h1234;
        @(negedge clk);
        MIO_EN = 1'b0;
        chk1("rst3_strobe", sram_en, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk1("rst3_R", R, 1'b0);
        chk16("rst3_rdata", mem_rdata, 16'h0000);
        exp_rdata = '0;
        @(negedge clk);
        rst = 1'b1;
        checkOutput("rst3", 4);
        applyStimulus(1'b0, 1'b1, 16'h0200, 16'h0000, 1'b0, 16'h0000);

        $display("[TB] reset in cycle 1 of a write");
        @(negedge clk);
        MIO_EN = 1'b1; R_W = 1'b1; DATA_SIZE = 1'b1; MAR = 16'h0300; MDR = 16'h5555;
        #2;
        rst    = 1'b0;
        MIO_EN = 1'b0;
        exp_rdata = '0;
        @(negedge clk);
        rst = 1'b1;
        checkOutput("rst1", 4);
        applyStimulus(1'b0, 1'b1, 16'h0300, 16'h0000, 1'b0, 16'h0000);

        $display("[TB] word read at odd address 0101");
        applyStimulus(1'b0, 1'b1, 16'h0101, 16'h0000, 1'b0, 16'h0000);
        applyStimulus(1'b1, 1'b1, 16'h0103, 16'h7777, 1'b0, 16'h0000);
        applyStimulus(1'b0, 1'b1, 16'h0102, 16'h0000, 1'b0, 16'h0000);

        $display("[TB] random accesses");
        for (int i = 0; i < 40; i++) begin
            rw   = 1'($urandom_range(0, 1));
            sz   = 1'($urandom_range(0, 1));
            a    = 16'h0400 + 16'($urandom_range(0, 31));
            hold = (i < 39) ? bit'($urandom_range(0, 1)) : 1'b0;
            applyStimulus(rw, sz, a, 16'($urandom), hold, 16'($urandom));
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lc3b_mem_ctrl.md
# lc3b_mem_ctrl

Memory controller between the LC-3b datapath's memory-interface signals (MIO_EN, R_W, DATA_SIZE, MAR, MDR) and a single-port synchronous SRAM. It accepts one access at a time and issues exactly one SRAM strobe per access. It produces the ready signal R after a fixed, parameterised latency, which stalls the control FSM in its memory states. It also handles byte-lane selection for LDB/STB-style byte accesses.

## Interface
- MEM_LATENCY, 5, cycles from request acceptance to R high, inclusive; legal range 3–15.
- AW, 15, SRAM word-address width; byte address is MAR[AW:0].

Clock and reset are fixed as one clock, `clk`, with reset `rst`, which is asynchronous and active-low.

- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- MIO_EN  in  1  memory access request; sampled only in IDLE.
- R_W  in  1  1 = write, 0 = read.
- DATA_SIZE  in  1  1 = word, 0 = byte.
- MAR  in  16  byte address.
- MDR  in  16  write data.
- mem_rdata  out  16  read word, registered.
- R  out  1  ready; one-cycle pulse per access.
- unaligned  out  1  word access to an odd address; only present with LC3B_UNALIGNED_CHECK_EN.
- sram_en  out  1  SRAM strobe.
- sram_we  out  1  SRAM write enable.
- sram_be  out  2  byte enables; [1] is the high byte.
- sram_addr  out  AW  word address.
- sram_wdata  out  16  write data.
- sram_rdata  in  16  SRAM read data, valid one cycle after a read strobe.

## Operation
- FSM states are IDLE, STROBE, WAIT and DONE.
- **IDLE**
  - When MIO_EN=1, latch MAR, MDR, R_W and DATA_SIZE.
  - Load the counter with MEM_LATENCY-3, then go to STROBE.
  - Otherwise stay in IDLE.
- **STROBE**
  - Drive sram_en=1 for this cycle only.
  - sram_we is the latched R_W.
  - sram_addr is the latched MAR[AW:1].
  - Go to WAIT.
- **WAIT**
  - For a read, capture sram_rdata into mem_rdata on the first WAIT edge.
  - Decrement the counter each cycle.
  - When the counter reaches 0, go to DONE.
- **DONE**
  - R=1 for this cycle only, then go to IDLE.
- **Byte lanes**
  - A word access sets be=2'b11 and wdata=MDR.
  - A byte access sets be = MAR[0] ? 2'b10 : 2'b01 and wdata={MDR[7:0],MDR[7:0]}.
  - Reads always return the full word; byte extraction and sign extension are the datapath's job.
- The latched request is frozen for the whole access. Changes on MAR, MDR, R_W or MIO_EN after acceptance are ignored.
- If MIO_EN drops mid-access, the access still completes and R still pulses.
- If MIO_EN is still high when IDLE is re-entered, a new access is accepted; back-to-back accesses are allowed.
- mem_rdata holds its value until the next read capture. Writes do not change it.

## Timing
- Count the acceptance cycle (IDLE with MIO_EN=1) as cycle 1. Then:
  - sram_en is high in cycle 2.
  - mem_rdata is valid from cycle 4.
  - R is high in cycle MEM_LATENCY.
  - The earliest next acceptance is cycle MEM_LATENCY+1.
- Every output is registered. In particular, R is a flop output, not decoded combinationally from state.
- All outputs reset to 0. The FSM resets to IDLE.
- Reset mid-access:
  - Return to IDLE immediately and R never pulses.
  - An SRAM write already strobed stays committed.
  - A write not yet strobed is never issued.
- Exactly one sram_en pulse occurs per accepted access. sram_en is never high in IDLE, WAIT or DONE.

## Configuration
- LC3B_UNALIGNED_CHECK_EN defined:
  - A word access with MAR[0]=1 suppresses the SRAM strobe; sram_en stays 0 in STROBE.
  - The access completes with normal timing.
  - `unaligned` is high together with R for one cycle.
  - A read leaves mem_rdata unchanged.
- LC3B_UNALIGNED_CHECK_EN not defined:
  - The `unaligned` port and its logic are absent.
  - MAR[0] is ignored for word accesses.

## Structure
- lc3b_pkg holds:
  - the FSM state enum: IDLE, STROBE, WAIT, DONE;
  - SIZE_BYTE/SIZE_WORD and RW_READ/RW_WRITE constants;
  - the minimum-latency constant, 3.
- One sub-module, lc3b_mem_lanes, is natural: a combinational byte-enable and write-data replication unit with inputs size, addr[0] and MDR.

## Test plan
- Word read with MAR=16'h3000, SRAM word 0x1800 = 16'hBEEF, MEM_LATENCY=5 -> sram_en in cycle 2, R in cycle 5 only, mem_rdata=16'hBEEF.
- Byte write with MAR=16'h3001, MDR=16'h00A5 -> sram_be=2'b10, sram_wdata=16'hA5A5, sram_we=1; a subsequent word read returns 16'hA5xx with the low byte unchanged.
- MIO_EN held high across two reads, at 16'h0010 and then 16'h0020 -> two sram_en pulses 5 cycles apart, two R pulses, second read's data correct.
- rst asserted in cycle 3 of a write -> R stays 0 and the FSM is in IDLE. rst asserted in cycle 1 of a write -> no sram_en at all.
- MAR changed to 16'hFFFF in cycle 2 of a read at 16'h0100 -> sram_addr is 15'h0080.
- With LC3B_UNALIGNED_CHECK_EN, word read at 16'h0101 -> no sram_en, unaligned and R high together in cycle 5, mem_rdata unchanged.
